// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Result word divres = {remainder, quotient}; one quotient bit per cycle.
// Optional build macro DIV_EARLY_EN: when |opa| < |opb| the divide loop is
// skipped and the result is produced after a single busy cycle.
module div_iter #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            div_s,
  input  logic [DW-1:0]   opa,
  input  logic [DW-1:0]   opb,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] divres
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dvd_q, dvd_d;    // dividend shifting out, quotient shifting in
  logic [DW-1:0]   dvs_q, dvs_d;    // divisor magnitude
  logic [DW-1:0]   prem_q, prem_d;  // partial remainder
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;
  logic [2*DW-1:0] divres_q, divres_d;

  logic [DW-1:0]   mag_a, mag_b;
  logic [DW:0]     trial;
  logic            qbit;
  logic            early_hit;

  // Operand magnitudes; the most negative value wraps to itself, which is
  // what makes the signed overflow case come out as 0x80000000 rem 0.
  always_comb begin
    mag_a = (div_s && opa[DW-1]) ? -opa : opa;
    mag_b = (div_s && opb[DW-1]) ? -opb : opb;
  end

`ifdef DIV_EARLY_EN
  assign early_hit = (mag_a < mag_b);
`else
  assign early_hit = 1'b0;
`endif

  // Restoring step: the dropped prem MSB is always zero before the final step.
  always_comb begin
    trial = {1'b0, prem_q[DW-2:0], dvd_q[DW-1]} - {1'b0, dvs_q};
    qbit  = ~trial[DW];
  end

  // Next-state logic; cancel wins over start and leaves divres untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    prem_d   = prem_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    divres_d = divres_q;
    if (cancel) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            qsign_d = div_s & (opa[DW-1] ^ opb[DW-1]);
            rsign_d = div_s & opa[DW-1];
            cnt_d   = '0;
            dvs_d   = mag_b;
            if (opb == '0) begin
              // Divide by zero: no iteration, result straight out.
              state_d  = StDone;
              dvd_d    = mag_a;
              prem_d   = '0;
              divres_d = {opa, {DW{1'b1}}};
            end else if (early_hit) begin
              state_d = StFix;
              dvd_d   = '0;
              prem_d  = mag_a;
            end else begin
              state_d = StCalc;
              dvd_d   = mag_a;
              prem_d  = '0;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StCalc: begin
          prem_d = qbit ? trial[DW-1:0] : {prem_q[DW-2:0], dvd_q[DW-1]};
          dvd_d  = {dvd_q[DW-2:0], qbit};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          divres_d = {(rsign_q ? -prem_q : prem_q), (qsign_q ? -dvd_q : dvd_q)};
          state_d  = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      prem_q   <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      divres_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      prem_q   <= prem_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      divres_q <= divres_d;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    busy   = (state_q == StCalc) || (state_q == StFix);
    done   = (state_q == StDone);
    divres = divres_q;
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (DW=32).
// Build with +define+DIV_EARLY_EN to check the early-out variant.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst, start, div_s, cancel;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [63:0] divres;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIV_EARLY_EN
  localparam int SmallBusy = 1;
  localparam int SmallLat  = 2;
`else
  localparam int SmallBusy = 33;
  localparam int SmallLat  = 34;
`endif

  always #5 clk = ~clk;

  div_iter #(.DW(32), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .div_s(div_s), .opa(opa), .opb(opb),
    .cancel(cancel), .busy(busy), .done(done), .divres(divres)
  );

  // Issue one operation and follow it until done (bounded). Operands are
  // scrambled after acceptance. If now=1 start is driven in the current cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit now, output int busy_cnt, output int done_k,
                        output logic [63:0] res);
    if (!now) @(negedge clk);
    opa = a; opb = b; div_s = s; start = 1'b1;
    busy_cnt = 0; done_k = 0; res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; opa = ~a; opb = ~b; div_s = ~s;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_k = k; res = divres;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cancel = 1'b0; div_s = 1'b0; opa = 32'd5; opb = 32'd0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (divres !== 64'h0) begin
      n_err++; $display("FAIL reset_divres got %h want 0", divres);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [31:0] va [3] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] vb [3] = '{32'd7, 32'd2, 32'h10};
    logic [63:0] ve [3] = '{64'h00000002_0000000E, 64'h00000001_7FFFFFFC,
                            64'h0000000F_0FFFFFFF};
    int bc, dk;
    logic [63:0] r;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, 1'b0, bc, dk, r);
      n_vec++; if (dk !== 34) begin n_err++; $display("FAIL udiv%0d_latency got %0d want 34", i, dk); end
      n_vec++; if (bc !== 33) begin n_err++; $display("FAIL udiv%0d_busy got %0d want 33", i, bc); end
      n_vec++; if (r !== ve[i]) begin
        n_err++; $display("FAIL udiv%0d_result got %h want %h", i, r, ve[i]);
      end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL udiv%0d_pulse got %b want 0", i, done); end
      n_vec++; if (divres !== ve[i]) begin
        n_err++; $display("FAIL udiv%0d_hold got %h want %h", i, divres, ve[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF8};
    logic [31:0] vb [3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    logic [63:0] ve [3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                            64'hFFFFFFFE_00000002};
    int bc, dk;
    logic [63:0] r;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b1, 1'b0, bc, dk, r);
      n_vec++; if (dk !== 34) begin n_err++; $display("FAIL sdiv%0d_latency got %0d want 34", i, dk); end
      n_vec++; if (r !== ve[i]) begin
        n_err++; $display("FAIL sdiv%0d_result got %h want %h", i, r, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc, dk;
    logic [63:0] r;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, bc, dk, r);
    n_vec++; if (r !== 64'h00000000_80000000) begin
      n_err++; $display("FAIL overflow_result got %h want 0000000080000000", r);
    end
    // Start issued in the DONE cycle itself.
    run_op(32'd9, 32'd3, 1'b0, 1'b1, bc, dk, r);
    n_vec++; if (dk !== 34) begin n_err++; $display("FAIL b2b_latency got %0d want 34", dk); end
    n_vec++; if (bc !== 33) begin n_err++; $display("FAIL b2b_busy got %0d want 33", bc); end
    n_vec++; if (r !== 64'h00000000_00000003) begin
      n_err++; $display("FAIL b2b_result got %h want 0000000000000003", r);
    end
  endtask

  task automatic test_div_zero();
    int bc, dk;
    logic [63:0] r;
    run_op(32'd5, 32'd0, 1'b0, 1'b0, bc, dk, r);
    n_vec++; if (dk !== 1) begin n_err++; $display("FAIL dz_u_latency got %0d want 1", dk); end
    n_vec++; if (bc !== 0) begin n_err++; $display("FAIL dz_u_busy got %0d want 0", bc); end
    n_vec++; if (r !== 64'h00000005_FFFFFFFF) begin
      n_err++; $display("FAIL dz_u_result got %h want 00000005ffffffff", r);
    end
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, bc, dk, r);
    n_vec++; if (dk !== 1) begin n_err++; $display("FAIL dz_s_latency got %0d want 1", dk); end
    n_vec++; if (r !== 64'hFFFFFFF9_FFFFFFFF) begin
      n_err++; $display("FAIL dz_s_result got %h want fffffff9ffffffff", r);
    end
    @(negedge clk);
  endtask

  task automatic test_cancel(input logic [63:0] prev);
    int bc, dk, nd;
    logic [63:0] r;
    // Cancel together with start: start must be dropped.
    @(negedge clk);
    opa = 32'd1000; opb = 32'd3; div_s = 1'b0; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_start_busy got %b want 0", busy); end
    // Cancel on the 10th busy cycle.
    start = 1'b1;
    bc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
    end
    cancel = 1'b1;
    n_vec++; if (bc !== 10) begin n_err++; $display("FAIL cancel_busy_count got %0d want 10", bc); end
    @(negedge clk);
    cancel = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_idle got %b want 0", busy); end
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    n_vec++; if (nd !== 0) begin n_err++; $display("FAIL cancel_done got %0d pulses want 0", nd); end
    n_vec++; if (divres !== prev) begin
      n_err++; $display("FAIL cancel_divres got %h want %h", divres, prev);
    end
    run_op(32'd1000, 32'd3, 1'b0, 1'b0, bc, dk, r);
    n_vec++; if (dk !== 34) begin n_err++; $display("FAIL post_cancel_latency got %0d want 34", dk); end
    n_vec++; if (r !== 64'h00000001_0000014D) begin
      n_err++; $display("FAIL post_cancel_result got %h want 000000010000014d", r);
    end
  endtask

  task automatic test_small();
    int bc, dk;
    logic [63:0] r;
    run_op(32'd3, 32'd10, 1'b0, 1'b0, bc, dk, r);
    n_vec++; if (dk !== SmallLat) begin
      n_err++; $display("FAIL small_u_latency got %0d want %0d", dk, SmallLat);
    end
    n_vec++; if (bc !== SmallBusy) begin
      n_err++; $display("FAIL small_u_busy got %0d want %0d", bc, SmallBusy);
    end
    n_vec++; if (r !== 64'h00000003_00000000) begin
      n_err++; $display("FAIL small_u_result got %h want 0000000300000000", r);
    end
    run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0, bc, dk, r);
    n_vec++; if (dk !== SmallLat) begin
      n_err++; $display("FAIL small_s_latency got %0d want %0d", dk, SmallLat);
    end
    n_vec++; if (r !== 64'hFFFFFFFD_00000000) begin
      n_err++; $display("FAIL small_s_result got %h want fffffffd00000000", r);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    @(negedge clk);
    opa = 32'd100; opb = 32'd7; div_s = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_vec++; if (divres !== 64'h0) begin
      n_err++; $display("FAIL rst_mid_divres got %h want 0", divres);
    end
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    n_vec++; if (nd !== 0) begin n_err++; $display("FAIL rst_mid_done got %0d pulses want 0", nd); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_div_zero();
    test_cancel(64'hFFFFFFF9_FFFFFFFF);
    test_small();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
